apb_io_router: RTL and testbench

APB_IO_ROUTER -- requirements
Module: apb_io_router

---
 rtl/apb_io_router.sv | 173 +++++++++++++++++
 tb/tb_apb_io_router.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_io_router.sv
// APB upstream-to-downstream router: one upstream APB port fans out to NUM_SLAVES peripherals
// selected by address bits [15:8], with access timeout and a sticky error flag.
module apb_io_router #(
  parameter int NUM_SLAVES     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic [15:0]             up_paddr,
  input  logic                    up_psel,
  input  logic                    up_penable,
  input  logic                    up_pwrite,
  input  logic [7:0]              up_pwdata,
  output logic [7:0]              up_prdata,
  output logic                    up_pready,
  output logic                    up_pslverr,
  output logic [2:0]              dn_paddr,
  output logic [7:0]              dn_pwdata,
  output logic                    dn_pwrite,
  output logic [NUM_SLAVES-1:0]   dn_psel,
  output logic                    dn_penable,
  input  logic [8*NUM_SLAVES-1:0] dn_prdata,
  input  logic [NUM_SLAVES-1:0]   dn_pready,
  input  logic                    err_clr,
  output logic                    err_sticky
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_e;

  localparam logic [7:0] LastCnt = 8'(TIMEOUT_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [NUM_SLAVES-1:0]   sel_q, sel_d;
  logic                    pen_q, pen_d;
  logic                    rdy_q, rdy_d;
  logic                    slverr_q, slverr_d;
  logic                    sticky_q, sticky_d;
  logic                    pwrite_q, pwrite_d;
  logic [7:0]              rdata_q, rdata_d;
  logic [7:0]              pwdata_q, pwdata_d;
  logic [2:0]              paddr_q, paddr_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [NUM_SLAVES-1:0]   decSel;
  logic                    selReady;
  logic [7:0]              selData;
  logic                    unused_paddrBits;

  assign unused_paddrBits = ^up_paddr[7:3];

  // An all-zero decode marks the address as unmapped.
  always_comb begin
    decSel  = '0;
    selData = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (up_paddr[15:8] == 8'(i)) decSel[i] = 1'b1;
      if (sel_q[i]) selData = selData | dn_prdata[8*i +: 8];
    end
  end

  assign selReady = |(dn_pready & sel_q);

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    pen_d    = pen_q;
    rdy_d    = 1'b0;
    slverr_d = 1'b0;
    rdata_d  = 8'h00;
    cnt_d    = cnt_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    case (state_q)
      IDLE: begin
        sel_d = '0;
        pen_d = 1'b0;
        if (up_psel && !up_penable) begin
          state_d  = SETUP;
          sel_d    = decSel;
          paddr_d  = up_paddr[2:0];
          pwdata_d = up_pwdata;
          pwrite_d = up_pwrite;
        end
      end
      SETUP: begin
        if (!up_psel) begin
          state_d = IDLE;
          sel_d   = '0;
        end else if (|sel_q) begin
          state_d = ACCESS;
          pen_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          state_d  = DONE;
          rdy_d    = 1'b1;
          rdata_d  = 8'hFF;
          slverr_d = 1'b1;
        end
      end
      ACCESS: begin
        // A ready on the final allowed cycle still completes normally.
        if (!up_psel) begin
          state_d = IDLE;
          sel_d   = '0;
          pen_d   = 1'b0;
        end else if (selReady) begin
          state_d = DONE;
          sel_d   = '0;
          pen_d   = 1'b0;
          rdy_d   = 1'b1;
          rdata_d = pwrite_q ? 8'h00 : selData;
        end else if (cnt_q == LastCnt) begin
          state_d  = DONE;
          sel_d    = '0;
          pen_d    = 1'b0;
          rdy_d    = 1'b1;
          rdata_d  = 8'hFF;
          slverr_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        sel_d   = '0;
        pen_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Set takes priority over clear when both happen in the same cycle.
  assign sticky_d = (state_q == DONE && slverr_q) || (sticky_q && !err_clr);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      pen_q    <= 1'b0;
      rdy_q    <= 1'b0;
      slverr_q <= 1'b0;
      sticky_q <= 1'b0;
      rdata_q  <= 8'h00;
      cnt_q    <= 8'h00;
      paddr_q  <= 3'h0;
      pwdata_q <= 8'h00;
      pwrite_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      pen_q    <= pen_d;
      rdy_q    <= rdy_d;
      slverr_q <= slverr_d;
      sticky_q <= sticky_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
    end
  end

  assign up_prdata  = rdata_q;
  assign up_pready  = rdy_q;
  assign up_pslverr = slverr_q;
  assign dn_paddr   = paddr_q;
  assign dn_pwdata  = pwdata_q;
  assign dn_pwrite  = pwrite_q;
  assign dn_psel    = sel_q;
  assign dn_penable = pen_q;
  assign err_sticky = sticky_q;

endmodule

// File: tb/tb_apb_io_router.sv
// Testbench for apb_io_router: directed vector table, hand-written corner sequences and
// randomized transfers checked against a transaction-level reference model.
module tb_apb_io_router;

  localparam int NS    = 4;
  localparam int TO    = 16;
  localparam int NEVER = 1000;

  logic              clk = 1'b0;
  logic              n_rst;
  logic [15:0]       up_paddr;
  logic              up_psel, up_penable, up_pwrite;
  logic [7:0]        up_pwdata;
  logic [7:0]        up_prdata;
  logic              up_pready, up_pslverr;
  logic [2:0]        dn_paddr;
  logic [7:0]        dn_pwdata;
  logic              dn_pwrite;
  logic [NS-1:0]     dn_psel;
  logic              dn_penable;
  logic [8*NS-1:0]   dn_prdata;
  logic [NS-1:0]     dn_pready;
  logic              err_clr;
  logic              err_sticky;

  int                checks = 0;
  int                failures = 0;
  int                cycleNum = 0;
  int                lat [NS];
  int                waitCnt [NS];
  logic [7:0]        slaveData [NS];
  logic [NS-1:0]     noise;
  logic              modelSticky;

  typedef struct {
    logic [15:0] addr;
    logic        wr;
    logic [7:0]  wdata;
    int          lat;
    logic [7:0]  sdata;
    int          expCyc;
    logic [7:0]  expRd;
    logic        expErr;
    logic [3:0]  expSel;
    int          expPen;
  } vec_t;

  typedef struct {
    int         doneCycle;
    int         doneAt;
    logic [7:0] rd;
    logic       err;
    logic [3:0] sel;
    int         pen;
    logic [2:0] paddr;
    logic [7:0] pwdata;
    logic       pwrite;
    logic       quiet;
  } obs_t;

  apb_io_router #(.NUM_SLAVES(NS), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .n_rst(n_rst),
    .up_paddr(up_paddr), .up_psel(up_psel), .up_penable(up_penable),
    .up_pwrite(up_pwrite), .up_pwdata(up_pwdata),
    .up_prdata(up_prdata), .up_pready(up_pready), .up_pslverr(up_pslverr),
    .dn_paddr(dn_paddr), .dn_pwdata(dn_pwdata), .dn_pwrite(dn_pwrite),
    .dn_psel(dn_psel), .dn_penable(dn_penable),
    .dn_prdata(dn_prdata), .dn_pready(dn_pready),
    .err_clr(err_clr), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleNum <= cycleNum + 1;

  // Slave i raises pready once it has waited lat[i] access cycles; noise drives unselected slaves.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (dn_psel[i] && dn_penable) waitCnt[i] <= waitCnt[i] + 1;
      else waitCnt[i] <= 0;
    end
  end

  always_comb begin
    dn_prdata = '0;
    dn_pready = '0;
    for (int i = 0; i < NS; i++) begin
      dn_prdata[8*i +: 8] = slaveData[i];
      dn_pready[i] = (dn_psel[i] && dn_penable && waitCnt[i] >= lat[i]) || noise[i];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Expected result of one transfer straight from the routing rules.
  function automatic void refModel(input logic [15:0] addr, input logic wr, input int latency,
                                   input logic [7:0] sdata, output int cyc, output logic [7:0] rd,
                                   output logic err, output logic [3:0] sel, output int pen);
    int idx = int'(addr[15:8]);
    if (idx >= NS) begin
      cyc = 2; rd = 8'hFF; err = 1'b1; sel = 4'b0000; pen = 0;
    end else begin
      sel = 4'(1 << idx);
      if (latency >= TO) begin
        cyc = TO + 2; rd = 8'hFF; err = 1'b1; pen = TO;
      end else begin
        cyc = 3 + latency; rd = wr ? 8'h00 : sdata; err = 1'b0; pen = latency + 1;
      end
    end
  endfunction

  // Drives one upstream transfer; cycle 1 is the cycle after the edge that samples the setup.
  task automatic applyStimulus(input logic [15:0] addr, input logic wr, input logic [7:0] wdata,
                               output obs_t o);
    up_psel = 1'b1; up_penable = 1'b0; up_paddr = addr; up_pwrite = wr; up_pwdata = wdata;
    o.doneCycle = -1; o.doneAt = -1; o.rd = 8'h00; o.err = 1'b0; o.sel = '0; o.pen = 0;
    o.paddr = 3'h0; o.pwdata = 8'h00; o.pwrite = 1'b0; o.quiet = 1'b1;
    for (int c = 1; c <= 300 && o.doneCycle < 0; c++) begin
      @(posedge clk);
      @(negedge clk);
      up_penable = 1'b1;
      if (c == 1) begin
        o.paddr = dn_paddr; o.pwdata = dn_pwdata; o.pwrite = dn_pwrite;
      end
      o.sel = o.sel | dn_psel;
      if (dn_penable) o.pen++;
      if (up_pready) begin
        o.doneCycle = c; o.doneAt = cycleNum; o.rd = up_prdata; o.err = up_pslverr;
      end else if (up_prdata !== 8'h00 || up_pslverr !== 1'b0) begin
        o.quiet = 1'b0;
      end
    end
    up_psel = 1'b0; up_penable = 1'b0;
  endtask

  task automatic checkTransfer(input string tag, input obs_t o, input logic [15:0] addr,
                               input logic wr, input logic [7:0] wdata, input int cyc,
                               input logic [7:0] rd, input logic err, input logic [3:0] sel,
                               input int pen);
    checkOutput({tag, "_cycle"}, o.doneCycle, cyc);
    checkOutput({tag, "_prdata"}, {24'h0, o.rd}, {24'h0, rd});
    checkOutput({tag, "_pslverr"}, {31'h0, o.err}, {31'h0, err});
    checkOutput({tag, "_psel"}, {28'h0, o.sel}, {28'h0, sel});
    checkOutput({tag, "_penCycles"}, o.pen, pen);
    checkOutput({tag, "_dnPaddr"}, {29'h0, o.paddr}, {29'h0, addr[2:0]});
    checkOutput({tag, "_dnPwrite"}, {31'h0, o.pwrite}, {31'h0, wr});
    checkOutput({tag, "_dnPwdata"}, {24'h0, o.pwdata}, {24'h0, wdata});
    checkOutput({tag, "_quietOutsideDone"}, {31'h0, o.quiet}, 32'h1);
  endtask

  // Steps into the following IDLE cycle and checks the sticky flag, optionally clearing it.
  task automatic stickyStep(input string tag, input logic doClear);
    @(negedge clk);
    checkOutput({tag, "_errSticky"}, {31'h0, err_sticky}, {31'h0, modelSticky});
    if (doClear) begin
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      modelSticky = 1'b0;
      checkOutput({tag, "_errCleared"}, {31'h0, err_sticky}, 32'h0);
    end
  endtask

  task automatic setupSlaves(input logic [15:0] addr, input int l, input logic [7:0] sdata);
    logic [3:0] target;
    int idx = int'(addr[15:8]);
    target = (idx < NS) ? 4'(1 << idx) : 4'b0000;
    for (int i = 0; i < NS; i++) begin
      slaveData[i] = 8'($urandom);
      lat[i] = $urandom_range(0, 3);
    end
    if (idx < NS) begin
      slaveData[idx] = sdata;
      lat[idx] = l;
    end
    noise = 4'($urandom) & ~target;
  endtask

  vec_t vecs [8];
  obs_t o, o2;
  int   eCyc, ePen;
  logic [7:0] eRd;
  logic eErr;
  logic [3:0] eSel;
  logic seenReady;

  initial begin
    vecs[0] = '{16'h0103, 1'b0, 8'h00, 0,     8'h5A, 3,  8'h5A, 1'b0, 4'b0010, 1};
    vecs[1] = '{16'h0002, 1'b1, 8'hC3, 3,     8'h77, 6,  8'h00, 1'b0, 4'b0001, 4};
    vecs[2] = '{16'h0700, 1'b0, 8'h00, 0,     8'h00, 2,  8'hFF, 1'b1, 4'b0000, 0};
    vecs[3] = '{16'h0200, 1'b0, 8'h00, NEVER, 8'h12, 18, 8'hFF, 1'b1, 4'b0100, 16};
    vecs[4] = '{16'h0305, 1'b0, 8'h00, 15,    8'hA5, 18, 8'hA5, 1'b0, 4'b1000, 16};
    vecs[5] = '{16'h0400, 1'b1, 8'h3C, 0,     8'h00, 2,  8'hFF, 1'b1, 4'b0000, 0};
    vecs[6] = '{16'h0107, 1'b1, 8'h99, 1,     8'h44, 4,  8'h00, 1'b0, 4'b0010, 2};
    vecs[7] = '{16'h03FE, 1'b0, 8'h00, 2,     8'hE1, 5,  8'hE1, 1'b0, 4'b1000, 3};

    n_rst = 1'b0; up_paddr = '0; up_psel = 1'b0; up_penable = 1'b0; up_pwrite = 1'b0;
    up_pwdata = '0; err_clr = 1'b0; noise = '0; modelSticky = 1'b0;
    for (int i = 0; i < NS; i++) begin lat[i] = 0; slaveData[i] = 8'h00; end

    repeat (2) @(negedge clk);
    checkOutput("reset_dnPsel", {28'h0, dn_psel}, 32'h0);
    checkOutput("reset_dnPenable", {31'h0, dn_penable}, 32'h0);
    checkOutput("reset_upPready", {31'h0, up_pready}, 32'h0);
    checkOutput("reset_errSticky", {31'h0, err_sticky}, 32'h0);
    checkOutput("reset_upPrdata", {24'h0, up_prdata}, 32'h0);
    checkOutput("reset_upPslverr", {31'h0, up_pslverr}, 32'h0);
    n_rst = 1'b1;

    // Row 0 starts on the very first edge after reset release.
    for (int i = 0; i < 8; i++) begin
      setupSlaves(vecs[i].addr, vecs[i].lat, vecs[i].sdata);
      applyStimulus(vecs[i].addr, vecs[i].wr, vecs[i].wdata, o);
      checkTransfer($sformatf("vec%0d", i), o, vecs[i].addr, vecs[i].wr, vecs[i].wdata,
                    vecs[i].expCyc, vecs[i].expRd, vecs[i].expErr, vecs[i].expSel, vecs[i].expPen);
      modelSticky = modelSticky | vecs[i].expErr;
      stickyStep($sformatf("vec%0d", i), 1'b1);
    end

    // psel with penable already high in IDLE is not a setup.
    up_psel = 1'b1; up_penable = 1'b1; up_paddr = 16'h0100; noise = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("ignoreEnable%0d_psel", k), {28'h0, dn_psel}, 32'h0);
      checkOutput($sformatf("ignoreEnable%0d_pready", k), {31'h0, up_pready}, 32'h0);
    end
    up_psel = 1'b0; up_penable = 1'b0;
    @(negedge clk);

    // Back-to-back reads to slaves 0 and 3.
    lat[0] = 0; lat[3] = 0; slaveData[0] = 8'h11; slaveData[3] = 8'h33; noise = '0;
    applyStimulus(16'h0000, 1'b0, 8'h00, o);
    @(posedge clk);
    #1;
    applyStimulus(16'h0300, 1'b0, 8'h00, o2);
    checkOutput("b2b_first_prdata", {24'h0, o.rd}, 32'h11);
    checkOutput("b2b_second_prdata", {24'h0, o2.rd}, 32'h33);
    checkOutput("b2b_second_cycle", o2.doneCycle, 3);
    checkOutput("b2b_readySpacing", o2.doneAt - o.doneAt, 4);
    @(negedge clk);

    // Upstream abort during ACCESS.
    lat[2] = NEVER; noise = '0;
    up_psel = 1'b1; up_penable = 1'b0; up_paddr = 16'h0201; up_pwrite = 1'b0;
    @(negedge clk); up_penable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("abortAccess_penBefore", {31'h0, dn_penable}, 32'h1);
    checkOutput("abortAccess_pselBefore", {28'h0, dn_psel}, 32'h4);
    up_psel = 1'b0; up_penable = 1'b0;
    @(negedge clk);
    checkOutput("abortAccess_psel", {28'h0, dn_psel}, 32'h0);
    checkOutput("abortAccess_penable", {31'h0, dn_penable}, 32'h0);
    seenReady = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (up_pready) seenReady = 1'b1;
      @(negedge clk);
    end
    checkOutput("abortAccess_noPready", {31'h0, seenReady}, 32'h0);
    checkOutput("abortAccess_errSticky", {31'h0, err_sticky}, {31'h0, modelSticky});

    // Upstream abort during SETUP.
    up_psel = 1'b1; up_penable = 1'b0; up_paddr = 16'h0201;
    @(negedge clk);
    up_psel = 1'b0;
    @(negedge clk);
    checkOutput("abortSetup_psel", {28'h0, dn_psel}, 32'h0);
    checkOutput("abortSetup_penable", {31'h0, dn_penable}, 32'h0);
    checkOutput("abortSetup_pready", {31'h0, up_pready}, 32'h0);

    // Error and clear in the same cycle: the error wins.
    err_clr = 1'b1;
    applyStimulus(16'h0500, 1'b0, 8'h00, o);
    checkOutput("setWins_pslverr", {31'h0, o.err}, 32'h1);
    @(posedge clk);
    #1 err_clr = 1'b0;
    modelSticky = 1'b1;
    stickyStep("setWins", 1'b1);

    // Asynchronous reset in the middle of ACCESS, with the sticky flag set beforehand.
    applyStimulus(16'h0600, 1'b0, 8'h00, o);
    modelSticky = 1'b1;
    stickyStep("preReset", 1'b0);
    lat[2] = NEVER;
    up_psel = 1'b1; up_penable = 1'b0; up_paddr = 16'h0202;
    @(negedge clk); up_penable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    checkOutput("asyncReset_psel", {28'h0, dn_psel}, 32'h0);
    checkOutput("asyncReset_penable", {31'h0, dn_penable}, 32'h0);
    checkOutput("asyncReset_pready", {31'h0, up_pready}, 32'h0);
    checkOutput("asyncReset_errSticky", {31'h0, err_sticky}, 32'h0);
    up_psel = 1'b0; up_penable = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    modelSticky = 1'b0;
    setupSlaves(16'h0103, 0, 8'h5A);
    applyStimulus(16'h0103, 1'b0, 8'h00, o);
    checkTransfer("postReset", o, 16'h0103, 1'b0, 8'h00, 3, 8'h5A, 1'b0, 4'b0010, 1);
    stickyStep("postReset", 1'b0);

    // Randomized transfers against the reference model.
    for (int t = 0; t < 40; t++) begin
      logic [15:0] addr;
      logic        wr;
      logic [7:0]  wdata, sdata;
      int          l;
      addr  = {8'($urandom_range(0, 5)), 5'($urandom), 3'($urandom_range(0, 7))};
      wr    = 1'($urandom_range(0, 1));
      wdata = 8'($urandom);
      sdata = 8'($urandom);
      l     = $urandom_range(0, 7);
      if (l == 7) l = $urandom_range(14, 17);
      setupSlaves(addr, l, sdata);
      refModel(addr, wr, l, sdata, eCyc, eRd, eErr, eSel, ePen);
      applyStimulus(addr, wr, wdata, o);
      checkTransfer($sformatf("rand%0d", t), o, addr, wr, wdata, eCyc, eRd, eErr, eSel, ePen);
      modelSticky = modelSticky | eErr;
      stickyStep($sformatf("rand%0d", t), ($urandom_range(0, 2) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
